// File: rtl/mem_lsu_pkg.sv
// Shared types and the alignment rule for the load/store unit.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // The reserved size encoding is rejected the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lo[0];
            SIZE_W:  bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational, no backpressure.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    always_comb begin
        w_byte    = i_rdata[8*i_lane +: 8];
        w_half    = i_rdata[16*i_lane[1] +: 16];
        w_sign    = 1'b0;
        o_ld_data = i_rdata;
        case (i_size)
            SIZE_B: begin
                w_sign    = ~i_unsigned & w_byte[7];
                o_ld_data = {{24{w_sign}}, w_byte};
            end
            SIZE_H: begin
                w_sign    = ~i_unsigned & w_half[15];
                o_ld_data = {{16{w_sign}}, w_half};
            end
            default: o_ld_data = i_rdata;
        endcase
    end

    // Untouched lanes keep the word just read back from memory.
    always_comb begin
        o_st_word = i_rdata;
        case (i_size)
            SIZE_B:  o_st_word[8*i_lane +: 8]       = i_wdata[7:0];
            SIZE_H:  o_st_word[16*i_lane[1] +: 16]  = i_wdata[15:0];
            default: o_st_word = i_wdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// CPU load/store to word-bus initiator (RMW for sub-word stores); resp +1 misaligned, +2 load/word store, +3 sub-word store.
// req_ready only in IDLE; no response backpressure. MEM_LSU_TIMEOUT_EN adds a bus-wait timeout.
module mem_lsu
    import mem_lsu_pkg::*;
`ifdef MEM_LSU_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wstrobe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done
);

    state_e      r_state;
    state_e      w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_misal;
    logic        w_timeout;
    logic [31:0] w_ld_data;
    logic [31:0] w_st_word;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_misal  = is_misaligned(req_size, req_addr[1:0]);

    assign req_ready   = (r_state == IDLE);
    assign resp_valid  = (r_state == RESP);
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign mem_addr    = {r_addr[31:2], 2'b00};
    assign mem_wdata   = r_mem_wdata;
    // Decoded straight from the state so an async reset drops it immediately.
    assign mem_wstrobe = (r_state == WR);

    mem_lsu_align u_align (
        .i_size     (r_size),
        .i_lane     (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_rdata    (mem_rdata),
        .i_wdata    (r_wdata),
        .o_ld_data  (w_ld_data),
        .o_st_word  (w_st_word)
    );

`ifdef MEM_LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_cnt;

    // Counts cycles spent in the current bus state; restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == RD) || (r_state == WR)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = ((r_state == RD) || (r_state == WR)) && !mem_done
                       && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misal) begin
                        w_next = RESP;
                    end else if (req_we && (req_size == SIZE_W)) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD: begin
                if (mem_done) begin
                    w_next = r_we ? WR : RESP;
                end else if (w_timeout) begin
                    w_next = RESP;
                end
            end
            WR: begin
                if (mem_done || w_timeout) begin
                    w_next = RESP;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_wdata  <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else if (w_accept) begin
            r_we         <= req_we;
            r_size       <= req_size;
            r_unsigned   <= req_unsigned;
            r_addr       <= req_addr;
            r_wdata      <= req_wdata;
            r_resp_rdata <= '0;
            r_resp_err   <= w_misal;
            if (req_we && (req_size == SIZE_W) && !w_misal) begin
                r_mem_wdata <= req_wdata;
            end
        end else if ((r_state == RD) && mem_done) begin
            if (r_we) begin
                r_mem_wdata <= w_st_word;
            end else begin
                r_resp_rdata <= w_ld_data;
            end
        end else if (w_timeout) begin
            r_resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, RMW stores, misalignment, stalled bus and mid-write reset.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wstrobe;
    logic [31:0] mem_rdata;
    logic        mem_done;

    int checks = 0;
    int errors = 0;

    mem_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrobe  (mem_wstrobe),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and follows it to its response.
    task automatic xact(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic [31:0] wr_word, output int ws_cnt, output logic [31:0] bus_addr);
        int n;
        n = 0;
        while (!req_ready && n < 8) begin
            tick();
            n++;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid = 1'b0;
        n        = 1;
        ws_cnt   = 0;
        wr_word  = 32'h0;
        bus_addr = mem_addr;
        while (!resp_valid && n < 64) begin
            if (mem_wstrobe) begin
                ws_cnt++;
                wr_word = mem_wdata;
            end
            tick();
            n++;
        end
        lat   = n;
        rdata = resp_rdata;
        err   = resp_err;
        if (!resp_valid) chk({tag, "_resp_seen"}, {31'h0, resp_valid}, 32'h1);
        tick();
        chk({tag, "_pulse_end"}, {31'h0, resp_valid}, 32'h0);
    endtask

    int          lat, ws;
    logic [31:0] rd, ww, ba;
    logic        er;

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_rdata    = 32'h0;
        mem_done     = 1'b1;
        tick();
        tick();
        chk("rst_ready",  {31'h0, req_ready},   32'h1);
        chk("rst_valid",  {31'h0, resp_valid},  32'h0);
        chk("rst_err",    {31'h0, resp_err},    32'h0);
        chk("rst_rdata",  resp_rdata,           32'h0);
        chk("rst_maddr",  mem_addr,             32'h0);
        chk("rst_mwdata", mem_wdata,            32'h0);
        chk("rst_wstrb",  {31'h0, mem_wstrobe}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Word load
        mem_rdata = 32'h8badf00d;
        xact("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er, ww, ws, ba);
        chk("lw_lat",   lat,          32'd2);
        chk("lw_rdata", rd,           32'h8badf00d);
        chk("lw_err",   {31'h0, er},  32'h0);
        chk("lw_addr",  ba,           32'h100);

        // Byte / half loads, signed and unsigned
        mem_rdata = 32'h80123456;
        xact("lb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, rd, er, ww, ws, ba);
        chk("lb_rdata", rd, 32'hffffff80);
        chk("lb_addr",  ba, 32'h100);
        xact("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, rd, er, ww, ws, ba);
        chk("lbu_rdata", rd, 32'h00000080);
        xact("lh2", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, rd, er, ww, ws, ba);
        chk("lh2_rdata", rd, 32'hffff8012);
        mem_rdata = 32'h1234abcd;
        xact("lhu0", 1'b0, 2'b01, 1'b1, 32'h000, 32'h0, lat, rd, er, ww, ws, ba);
        chk("lhu0_rdata", rd, 32'h0000abcd);
        xact("lb1", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, lat, rd, er, ww, ws, ba);
        chk("lb1_rdata", rd, 32'hffffffab);
        chk("lb1_lat",   lat, 32'd2);

        // Sub-word stores via read-modify-write
        mem_rdata = 32'h11223344;
        xact("sb", 1'b1, 2'b00, 1'b0, 32'h102, 32'h000000aa, lat, rd, er, ww, ws, ba);
        chk("sb_lat",   lat, 32'd3);
        chk("sb_wword", ww,  32'h11aa3344);
        chk("sb_wscnt", ws,  32'd1);
        chk("sb_rdata", rd,  32'h0);
        chk("sb_err",   {31'h0, er}, 32'h0);
        xact("sh", 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234beef, lat, rd, er, ww, ws, ba);
        chk("sh_wword", ww, 32'hbeef3344);
        xact("sb0", 1'b1, 2'b00, 1'b0, 32'h100, 32'hffffff55, lat, rd, er, ww, ws, ba);
        chk("sb0_wword", ww, 32'h11223355);

        // Word store goes straight to WR
        xact("sw", 1'b1, 2'b10, 1'b0, 32'h200, 32'hcafef00d, lat, rd, er, ww, ws, ba);
        chk("sw_lat",   lat, 32'd2);
        chk("sw_wword", ww,  32'hcafef00d);
        chk("sw_addr",  ba,  32'h200);

        // Misaligned and reserved-size requests
        xact("lh_mis", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, lat, rd, er, ww, ws, ba);
        chk("lh_mis_lat",   lat, 32'd1);
        chk("lh_mis_err",   {31'h0, er}, 32'h1);
        chk("lh_mis_rdata", rd,  32'h0);
        chk("lh_mis_wscnt", ws,  32'd0);
        xact("sw_mis", 1'b1, 2'b10, 1'b0, 32'h202, 32'h12345678, lat, rd, er, ww, ws, ba);
        chk("sw_mis_err",   {31'h0, er}, 32'h1);
        chk("sw_mis_wscnt", ws,  32'd0);
        xact("sz3", 1'b0, 2'b11, 1'b0, 32'h300, 32'h0, lat, rd, er, ww, ws, ba);
        chk("sz3_err", {31'h0, er}, 32'h1);
        chk("sz3_lat", lat, 32'd1);

        // Word store with mem_done held low for 4 cycles in WR
        begin
            int ws_hi;
            int addr_bad;
            mem_done  = 1'b0;
            ws_hi     = 0;
            addr_bad  = 0;
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_size  = 2'b10;
            req_addr  = 32'h300;
            req_wdata = 32'h0badcafe;
            tick();
            req_valid = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (i == 4) mem_done = 1'b1;
                if (mem_wstrobe) ws_hi++;
                if (mem_addr != 32'h300 || mem_wdata != 32'h0badcafe) addr_bad++;
                tick();
            end
            chk("stall_wscnt",   ws_hi,    32'd5);
            chk("stall_stable",  addr_bad, 32'd0);
            chk("stall_resp",    {31'h0, resp_valid},  32'h1);
            chk("stall_wsdrop",  {31'h0, mem_wstrobe}, 32'h0);
            tick();
        end

        // Reset in the middle of a stalled word store
        mem_done  = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h400;
        req_wdata = 32'h55aa55aa;
        tick();
        req_valid = 1'b0;
        chk("rstwr_wstrb_pre", {31'h0, mem_wstrobe}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstwr_wstrb_async", {31'h0, mem_wstrobe}, 32'h0);
        chk("rstwr_maddr",       mem_addr, 32'h0);
        tick();
        rst_n    = 1'b1;
        mem_done = 1'b1;
        tick();
        chk("rstwr_ready", {31'h0, req_ready},  32'h1);
        chk("rstwr_valid", {31'h0, resp_valid}, 32'h0);

        // Operation resumes normally after reset
        mem_rdata = 32'h13579bdf;
        xact("lw_post", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, lat, rd, er, ww, ws, ba);
        chk("lw_post_rdata", rd, 32'h13579bdf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
